chip8_delay_sound_timers: RTL and testbench

//   Consumer end of the 60 Hz tick: holds the CHIP-8 delay timer (DT) and sound timer (ST).
//   CPU core writes DT/ST (FX15/FX18) and reads DT (FX07). Each timer decrements once per tick while nonzero.

---
 rtl/chip8_delay_sound_timers_pkg.sv | 22 ++
 rtl/chip8_delay_sound_timers_tone_gen.sv | 32 +++
 rtl/chip8_delay_sound_timers.sv | 65 ++++++
 tb/tb_chip8_delay_sound_timers.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/chip8_delay_sound_timers_pkg.sv
// Shared definitions for the CHIP-8 delay/sound timer block: timer width, write selectors,
// platform clock default and the tone divider helper.
package chip8_delay_sound_timers_pkg;

  localparam int unsigned TIMER_W = 8;

  typedef enum logic {
    TSEL_DT = 1'b0,
    TSEL_ST = 1'b1
  } tsel_e;

  localparam int unsigned CLOCK_SPEED_HZ = 25_000_000;

  // Half-period of the tone in clk cycles, clamped so the divider always has at least one state.
  function automatic int unsigned tone_half(input int unsigned clk_hz, input int unsigned tone_hz);
    int unsigned half;
    if (tone_hz == 0) return 1;
    half = clk_hz / (2 * tone_hz);
    return (half == 0) ? 1 : half;
  endfunction

endpackage

// File: rtl/chip8_delay_sound_timers_tone_gen.sv
// Square-wave divider for the buzzer: toggles tone_out every HALF_PERIOD cycles while enabled,
// and holds divider and phase at zero while disabled so every beep starts low.
module chip8_tone_gen #(
  parameter int unsigned HALF_PERIOD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tone_out
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      tone_out <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      tone_out <= 1'b0;
    end else if (cnt == LAST) begin
      cnt      <= '0;
      tone_out <= ~tone_out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chip8_delay_sound_timers.sv
// CHIP-8 delay (DT) and sound (ST) timers: CPU load, saturating 60 Hz decrement, buzzer drive.
// Define CHIP8_TONE_EN for a TONE_HZ square wave on audio_out; otherwise audio_out = sound_on.
module chip8_delay_sound_timers
  import chip8_delay_sound_timers_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLOCK_SPEED_HZ,
  parameter int unsigned TONE_HZ = 440
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_60hz,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [TIMER_W-1:0] wr_data,
  output logic [TIMER_W-1:0] dt_value,
  output logic [TIMER_W-1:0] st_value,
  output logic               dt_zero,
  output logic               sound_on,
  output logic               audio_out
);

  logic wr_dt;
  logic wr_st;

  assign wr_dt = wr_en && (wr_sel == TSEL_DT);
  assign wr_st = wr_en && (wr_sel == TSEL_ST);

  // A write wins over a tick on the same edge for the targeted timer only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_value <= '0;
      st_value <= '0;
    end else begin
      if (wr_dt) dt_value <= wr_data;
      else if (tick_60hz && (dt_value != '0)) dt_value <= dt_value - 1'b1;

      if (wr_st) st_value <= wr_data;
      else if (tick_60hz && (st_value != '0)) st_value <= st_value - 1'b1;
    end
  end

  assign dt_zero  = (dt_value == '0);
  assign sound_on = (st_value != '0);

`ifdef CHIP8_TONE_EN
  logic tone;

  chip8_tone_gen #(
    .HALF_PERIOD(tone_half(CLK_HZ, TONE_HZ))
  ) u_tone_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (sound_on),
    .tone_out (tone)
  );

  // The divider clears one edge after sound_on drops; gating hides that last cycle.
  assign audio_out = sound_on & tone;
`else
  logic cfg_unused;
  assign cfg_unused = ^(CLK_HZ ^ TONE_HZ);
  assign audio_out  = sound_on;
`endif

endmodule

// File: tb/tb_chip8_delay_sound_timers.sv
// Self-checking bench for chip8_delay_sound_timers: cycle-level model plus directed literal checks.
module tb_chip8_delay_sound_timers;
  import chip8_delay_sound_timers_pkg::*;

  localparam int unsigned CLK_HZ  = 8800;
  localparam int unsigned TONE_HZ = 440;
  localparam int          HALF    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_60hz = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] dt_value;
  logic [7:0] st_value;
  logic       dt_zero;
  logic       sound_on;
  logic       audio_out;

  int assertions = 0;
  int failures   = 0;

  // Model state: timer values and number of clk edges ST has been continuously nonzero.
  int m_dt = 0;
  int m_st = 0;
  int m_on = 0;

  chip8_delay_sound_timers #(
    .CLK_HZ  (CLK_HZ),
    .TONE_HZ (TONE_HZ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_60hz (tick_60hz),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .dt_value  (dt_value),
    .st_value  (st_value),
    .dt_zero   (dt_zero),
    .sound_on  (sound_on),
    .audio_out (audio_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_audio();
`ifdef CHIP8_TONE_EN
    return ((m_st != 0) && (((m_on / HALF) % 2) == 1)) ? 1 : 0;
`else
    return (m_st != 0) ? 1 : 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int prev_st;
    if (!rst_n) begin
      m_dt = 0;
      m_st = 0;
      m_on = 0;
    end else begin
      prev_st = m_st;
      if (wr_en && wr_sel == TSEL_DT) m_dt = int'(wr_data);
      else if (tick_60hz) m_dt = (m_dt > 0) ? m_dt - 1 : 0;
      if (wr_en && wr_sel == TSEL_ST) m_st = int'(wr_data);
      else if (tick_60hz) m_st = (m_st > 0) ? m_st - 1 : 0;
      m_on = (m_st != 0 && prev_st != 0) ? m_on + 1 : 0;
    end
  end

  always @(negedge clk) begin
    check("cyc_dt_value", int'(dt_value), m_dt);
    check("cyc_st_value", int'(st_value), m_st);
    check("cyc_dt_zero", int'(dt_zero), (m_dt == 0) ? 1 : 0);
    check("cyc_sound_on", int'(sound_on), (m_st != 0) ? 1 : 0);
    check("cyc_audio_out", int'(audio_out), exp_audio());
  end

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic cyc(input logic t, input logic w, input logic sel, input logic [7:0] d);
    tick_60hz = t;
    wr_en     = w;
    wr_sel    = sel;
    wr_data   = d;
    @(posedge clk);
    #1;
    tick_60hz = 1'b0;
    wr_en     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic tick_after(input int gap);
    idle(gap);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_dt", int'(dt_value), 0);
    check("rst_st", int'(st_value), 0);
    check("rst_dt_zero", int'(dt_zero), 1);
    check("rst_sound_on", int'(sound_on), 0);
    check("rst_audio", int'(audio_out), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DT countdown with saturation at zero
    cyc(1'b0, 1'b1, TSEL_DT, 8'd3);
    check("dt_load3", int'(dt_value), 3);
    check("dt_zero_after_load", int'(dt_zero), 0);
    tick_after(2); check("dt_tick1", int'(dt_value), 2);
    tick_after(2); check("dt_tick2", int'(dt_value), 1);
    check("dt_zero_tick2", int'(dt_zero), 0);
    tick_after(2); check("dt_tick3", int'(dt_value), 0);
    check("dt_zero_tick3", int'(dt_zero), 1);
    tick_after(2); check("dt_tick4_sat", int'(dt_value), 0);

    // Tick held high for three cycles decrements three times
    cyc(1'b0, 1'b1, TSEL_DT, 8'd5);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    check("dt_held_tick", int'(dt_value), 2);

    // ST write coinciding with a tick: ST loads, DT still decrements
    cyc(1'b1, 1'b1, TSEL_ST, 8'd5);
    check("st_load_on_tick", int'(st_value), 5);
    check("dt_dec_beside_st_write", int'(dt_value), 1);
    tick_after(12); check("st_tick1", int'(st_value), 4);
    tick_after(12); tick_after(12); tick_after(12);
    check("st_tick4", int'(st_value), 1);
    check("sound_before_5th", int'(sound_on), 1);
    tick_after(12);
    check("st_tick5", int'(st_value), 0);
    check("sound_after_5th", int'(sound_on), 0);

    // Write ST = 0 mid-count; DT keeps counting
    cyc(1'b0, 1'b1, TSEL_DT, 8'd10);
    cyc(1'b1, 1'b1, TSEL_ST, 8'd10);
    check("st_load10", int'(st_value), 10);
    check("dt_9", int'(dt_value), 9);
    tick_after(3); tick_after(3);
    check("dt_7", int'(dt_value), 7);
    check("st_8", int'(st_value), 8);
    cyc(1'b0, 1'b1, TSEL_ST, 8'd0);
    check("st_cleared", int'(st_value), 0);
    check("sound_cleared", int'(sound_on), 0);
    check("dt_unchanged", int'(dt_value), 7);
    repeat (7) tick_after(2);
    check("dt_counted_out", int'(dt_value), 0);
    check("dt_zero_counted_out", int'(dt_zero), 1);

    // Asynchronous reset mid-count
    cyc(1'b0, 1'b1, TSEL_DT, 8'd7);
    cyc(1'b0, 1'b1, TSEL_ST, 8'd7);
    tick_after(1);
    check("dt_6_before_rst", int'(dt_value), 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dt", int'(dt_value), 0);
    check("async_rst_st", int'(st_value), 0);
    check("async_rst_dt_zero", int'(dt_zero), 1);
    check("async_rst_audio", int'(audio_out), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick_after(2); tick_after(2);
    check("dt_after_rst_ticks", int'(dt_value), 0);

    // Tone: low for the first half-period of a beep, then toggles every HALF cycles
    cyc(1'b0, 1'b1, TSEL_ST, 8'd3);
`ifdef CHIP8_TONE_EN
    check("tone_phase0", int'(audio_out), 0);
    idle(HALF);
    check("tone_high", int'(audio_out), 1);
    idle(HALF);
    check("tone_low_again", int'(audio_out), 0);
`else
    check("dc_audio_on", int'(audio_out), 1);
    idle(HALF);
    check("dc_audio_still_on", int'(audio_out), 1);
    idle(HALF);
    check("dc_audio_on_late", int'(audio_out), 1);
`endif
    tick_after(15); tick_after(15); tick_after(15);
    check("tone_st_done", int'(sound_on), 0);
    idle(3);
    check("audio_off_end", int'(audio_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
